// File: rtl/spr_dma_ctrl_if.sv
// Bus bundle for the sprite DMA controller: CPU-side trigger inputs, memory read data,
// and the DMA master outputs that feed the bus arbitration mux.
interface spr_dma_ctrl_if;
  logic [15:0] cpu_addr_in;
  logic        cpu_r_nw_in;
  logic [7:0]  cpu_data_in;
  logic [7:0]  bus_data_in;
  logic        cpu_rdy_out;
  logic        dma_active_out;
  logic [15:0] dma_addr_out;
  logic        dma_r_nw_out;
  logic [7:0]  dma_data_out;
  logic        dma_done_out;

  modport slave (
    input  cpu_addr_in,
    input  cpu_r_nw_in,
    input  cpu_data_in,
    input  bus_data_in,
    output cpu_rdy_out,
    output dma_active_out,
    output dma_addr_out,
    output dma_r_nw_out,
    output dma_data_out,
    output dma_done_out
  );

  modport master (
    output cpu_addr_in,
    output cpu_r_nw_in,
    output cpu_data_in,
    output bus_data_in,
    input  cpu_rdy_out,
    input  dma_active_out,
    input  dma_addr_out,
    input  dma_r_nw_out,
    input  dma_data_out,
    input  dma_done_out
  );
endinterface

// File: rtl/spr_dma_ctrl.sv
// Sprite OAM DMA engine: a CPU write of page P to the DMA register stalls the CPU and copies
// $PP00-$PPFF into the PPU OAM data port, one bus cycle per clock, reads on even cycles only.
module spr_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input logic           clk_in,
  input logic           rst_n_in,
  spr_dma_ctrl_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StHalt, StAlign, StRead, StWrite} state_e;

  state_e     state_q, state_d;
  logic       q_odd_q;
  logic [7:0] page_q, page_d;
  logic [7:0] index_q, index_d;
  logic [7:0] buffer_q, buffer_d;
  logic       done_q, done_d;
  logic       trigger;

  assign trigger = (bus.cpu_addr_in == DMA_REG_ADDR) && !bus.cpu_r_nw_in;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= StIdle;
      q_odd_q  <= 1'b0;
      page_q   <= 8'h00;
      index_q  <= 8'h00;
      buffer_q <= 8'h00;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_odd_q  <= ~q_odd_q;
      page_q   <= page_d;
      index_q  <= index_d;
      buffer_q <= buffer_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    page_d   = page_q;
    index_d  = index_q;
    buffer_d = buffer_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Only IDLE listens for the trigger, so a stray write mid-transfer is ignored.
        if (trigger) begin
          page_d  = bus.cpu_data_in;
          index_d = 8'h00;
          state_d = StHalt;
        end
      end
      // An odd HALT cycle puts the first READ on an even cycle; otherwise pad one cycle.
      StHalt:  state_d = q_odd_q ? StRead : StAlign;
      StAlign: state_d = StRead;
      StRead: begin
        buffer_d = bus.bus_data_in;
        state_d  = StWrite;
      end
      StWrite: begin
        index_d = index_q + 8'h01;
        if (index_q == 8'hFF) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          state_d = StRead;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.cpu_rdy_out    = 1'b0;
    bus.dma_active_out = 1'b1;
    bus.dma_r_nw_out   = 1'b1;
    bus.dma_addr_out   = {page_q, 8'h00};
    bus.dma_data_out   = buffer_q;
    bus.dma_done_out   = done_q;
    unique case (state_q)
      StIdle: begin
        bus.cpu_rdy_out    = 1'b1;
        bus.dma_active_out = 1'b0;
        bus.dma_addr_out   = 16'h0000;
      end
      StHalt, StAlign: ;
      StRead:  bus.dma_addr_out = {page_q, index_q};
      StWrite: begin
        bus.dma_addr_out = OAM_DATA_ADDR;
        bus.dma_r_nw_out = 1'b0;
      end
      default: begin
        bus.cpu_rdy_out    = 1'b1;
        bus.dma_active_out = 1'b0;
        bus.dma_addr_out   = 16'h0000;
      end
    endcase
  end

endmodule
